// File: rtl/mem_req_ctrl.sv
// Initiator side of the shared memory port: word-wide loads with lane extraction and
// sign/zero extension, and read-modify-write for sub-word stores. Optional: MISALIGN_TRAP_EN.
module mem_req_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;

  logic              is_byte, is_half, is_word;
  logic              req_misaligned;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) is a word.
  assign is_byte = (funct3_q[1:0] == 2'b00);
  assign is_half = (funct3_q[1:0] == 2'b01);
  assign is_word = funct3_q[1];

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  assign req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                          (funct3[1] && (addr[1:0] != 2'b00));
  assign err = (state_q == S_DONE) && err_q;
`else
  assign req_misaligned = 1'b0;
  assign err            = 1'b0;
`endif

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign rdata = rdata_q;
  assign mem_a = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    byte_lane = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    half_lane = mem_rd[{addr_q[1], 4'b0000} +: 16];
    load_ext  = mem_rd;
    if (is_byte) begin
      load_ext = funct3_q[2] ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
    end else if (is_half) begin
      load_ext = funct3_q[2] ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
    end
  end

  always_comb begin
    merged = merge_q;
    if (is_byte) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (is_half) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    mem_wd  = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = req_misaligned ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q && !is_word) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DONE;
          if (we_q) begin
            mem_we = 1'b1;
            mem_wd = wdata_q;
          end
        end
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        mem_wd  = merged;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        funct3_q <= funct3;
        we_q     <= we;
`ifdef MISALIGN_TRAP_EN
        err_q    <= req_misaligned;
`endif
      end
      if (state_q == S_ACCESS) begin
        if (we_q) begin
          merge_q <= mem_rd;
        end else begin
          rdata_q <= load_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed cases plus random traffic against a
// word-array reference model of the memory and the load/store rules.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_rdata;
  logic        pl_en = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_data = 32'd0;

  int vectors = 0;
  int miscompares = 0;

  mem_req_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[11:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[11:2]] <= mem_wd;
    else if (pl_en) mem[pl_idx[9:0]] <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [31:0] a);
    logic [31:0] s;
    case (f3[1:0])
      2'b00: begin
        s = word >> (8 * a[1:0]);
        return f3[2] ? (s & 32'hFF) : {{24{s[7]}}, s[7:0]};
      end
      2'b01: begin
        s = word >> (16 * a[1]);
        return f3[2] ? (s & 32'hFFFF) : {{16{s[15]}}, s[15:0]};
      end
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    case (f3[1:0])
      2'b00: begin
        mask = 32'hFF << (8 * a[1:0]);
        return (old & ~mask) | ((wd & 32'hFF) << (8 * a[1:0]));
      end
      2'b01: begin
        mask = 32'hFFFF << (16 * a[1]);
        return (old & ~mask) | ((wd & 32'hFFFF) << (16 * a[1]));
      end
      default: return wd;
    endcase
  endfunction

  function automatic bit trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input bit hold);
    int idx, lat, wcnt, exp_lat;
    bit t;
    logic [31:0] new_word;
    idx = int'(a[11:2]);
    t = trap(f3, a);
    new_word = w ? store_merge(ref_mem[idx], f3, a, wd) : ref_mem[idx];
    exp_lat = t ? 1 : ((w && !f3[1]) ? 3 : 2);

    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    lat = 1;
    wcnt = 0;
    chk("busy_accept", {31'd0, busy}, 32'd1);
    chk("mem_a", mem_a, {a[31:2], 2'b00});
    while (!done && lat < 8) begin
      if (mem_we) begin
        wcnt++;
        chk("mem_wd", mem_wd, new_word);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("we_in_done", {31'd0, mem_we}, 32'd0);
    chk("writes", wcnt, (w && !t) ? 1 : 0);
    chk("err", {31'd0, err}, {31'd0, t});
    if (w && !t) ref_mem[idx] = new_word;
    if (!w && !t) ref_rdata = exp_load(ref_mem[idx], f3, a);
    @(posedge clk); #1;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("rdata", rdata, ref_rdata);
    chk("mem_word", mem[idx], ref_mem[idx]);
    if (hold) req = 1'b0;
    $display("txn we=%0d f3=%03b addr=%0d wdata=%h lat=%0d writes=%0d rdata=%h err=%0d",
             w, f3, a, wd, lat, wcnt, rdata, err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ref_rdata = 32'd0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_idx = i;
      pl_data = (i == 15) ? 32'd15 : (i == 600) ? 32'd600 : $urandom;
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
    rst = 1'b1;

    txn(1'b0, 3'b010, 32'd60, 32'd0, 1'b0);
    chk("lw60", rdata, 32'd15);
    txn(1'b1, 3'b000, 32'd2401, 32'h000000AB, 1'b0);
    chk("sb_word", mem[600], 32'h0000AB58);
    txn(1'b0, 3'b000, 32'd2401, 32'd0, 1'b0);
    chk("lb", rdata, 32'hFFFFFFAB);
    txn(1'b0, 3'b100, 32'd2401, 32'd0, 1'b0);
    chk("lbu", rdata, 32'h000000AB);
    txn(1'b0, 3'b001, 32'd2400, 32'd0, 1'b0);
    chk("lh", rdata, 32'hFFFFAB58);

    txn(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 1'b1);
    @(posedge clk); #1;
    chk("hold_no_reaccept", {31'd0, busy}, 32'd0);
    txn(1'b0, 3'b010, 32'd8, 32'd0, 1'b0);
    chk("lw8", rdata, 32'hDEADBEEF);

    // Reset in the WRITE cycle of an SH must abort the write.
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'd2008; wdata = 32'h1234CAFE;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("sh_write_cycle", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_mem_a", mem_a, 32'd0);
    ref_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    chk("arst_mem_kept", mem[502], ref_mem[502]);
    $display("txn reset during SH write to 2008: mem_we=%0d busy=%0d", mem_we, busy);
    txn(1'b0, 3'b010, 32'd2008, 32'd0, 1'b0);

    txn(1'b1, 3'b001, 32'd2401, 32'h0000BEEF, 1'b0);
    txn(1'b0, 3'b010, 32'd62, 32'd0, 1'b0);
    txn(1'b0, 3'b101, 32'd2403, 32'd0, 1'b0);
    txn(1'b0, 3'b011, 32'd2400, 32'd0, 1'b0);
    txn(1'b0, 3'b000, 32'd2400, 32'd0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 4095)),
          $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
